// File: rtl/multicycle_controller.sv
// Control FSM sequencing the shared-memory multicycle RV32I datapath.
// Latency: 3-5 cycles per instruction; all outputs are combinational, with no output register.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until MemReady; MemReady is ignored elsewhere.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       InstrDone,
  output logic       Illegal
);

  // Opcodes understood by this controller
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // ALU source / result select encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  // ALUOp values carried from the state to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JALRADR  = 4'd10,
    S_JAL      = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t state;
  state_t next_state;

  // Raw per-state controls, before reset gating
  logic       pc_update;
  logic       branch;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       instr_done;
  logic [1:0] alu_op;
  logic       funct3_ok;

  // Only add/sub, slt, or and and are implemented for R-type and I-ALU
  assign funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  // State register; reset returns to FETCH from any state, including TRAP
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = funct3_ok ? S_EXECR : S_TRAP;
          OP_I:         next_state = funct3_ok ? S_EXECI : S_TRAP;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          OP_JALR:      next_state = S_JALRADR;
          OP_LUI:       next_state = S_LUI;
          default:      next_state = S_TRAP;
        endcase
      end
      // op[5] separates sw (0100011) from lw (0000011)
      S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
      S_JALRADR:  next_state = S_JAL;
      S_JAL:      next_state = S_ALUWB;
      S_LUI:      next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_FETCH;
    endcase
  end

  // Per-state datapath controls; anything not set stays 0
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    instr_done = 1'b0;
    alu_op     = ALUOP_ADD;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_WD;
    Illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        ir_write  = MemReady;
        pc_update = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_write  = 1'b1;
        instr_done = MemReady;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_WD;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_WD;
        alu_op     = ALUOP_SUB;
        ResultSrc  = RES_ALUOUT;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JALRADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      // PC takes the target held in ALUOut while ALUOut becomes OldPC + 4
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        pc_update = 1'b1;
      end
      S_LUI: begin
        ResultSrc  = RES_IMM;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      // TRAP is absorbing, so the flag stays up until reset
      S_TRAP: begin
        Illegal = 1'b1;
      end
      default: begin
        Illegal = 1'b0;
      end
    endcase
  end

  // Write enables are held low for as long as reset is asserted
  always_comb begin
    PCWrite   = reset_n & (pc_update | (branch & Zero));
    IRWrite   = reset_n & ir_write;
    RegWrite  = reset_n & reg_write;
    MemWrite  = reset_n & mem_write;
    InstrDone = reset_n & instr_done;
  end

  // Immediate format depends only on the opcode
  always_comb begin
    case (op)
      OP_LW, OP_JALR, OP_I: ImmSrc = 3'b000;
      OP_SW:                ImmSrc = 3'b001;
      OP_BEQ:               ImmSrc = 3'b010;
      OP_JAL:               ImmSrc = 3'b011;
      OP_LUI:               ImmSrc = 3'b100;
      default:              ImmSrc = 3'b000;
    endcase
  end

  // ALU decoder; op[5] distinguishes R-type sub from addi with imm[10] set
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      ALUOP_ADD: ALUControl = 3'b000;
      ALUOP_SUB: ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default:   ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       InstrDone;
  logic       Illegal;

  int n_checks = 0;
  int n_fails  = 0;

  // Instruction classes used by the reference model
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_ILL = 8;

  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .InstrDone(InstrDone), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycles per instruction with MemReady always 1
  function automatic int base_cycles(input int cls);
    case (cls)
      C_LW, C_JALR:       return 5;
      C_SW, C_R, C_I, C_JAL: return 4;
      default:            return 3;
    endcase
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (f7 && o == 7'b0110011) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  // Holds reset for n cycles with MemReady high, then releases and checks FETCH idle outputs
  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n  = 1'b0;
      MemReady = 1'b1;
      Zero     = 1'b1;
      #1;
      check("rst_enables", {27'd0, PCWrite, IRWrite, RegWrite, MemWrite, InstrDone}, 32'd0);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    MemReady = 1'b0;
    #1;
    check("rst_fetch", {19'd0, AdrSrc, IRWrite, PCWrite, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Illegal},
          {19'd0, 13'b0_0_0_00_10_10_000_0});
  endtask

  // One instruction: w0 wait cycles in fetch, w1 wait cycles at the data access; zf < 0 randomises Zero
  task automatic run_instr(input int cls, input logic [6:0] iop, input logic [2:0] if3,
                           input logic if7, input int w0, input int w1, input int zf);
    bit is_mem  = (cls == C_LW) || (cls == C_SW);
    int exp_cyc = base_cycles(cls) + w0 + (is_mem ? w1 : 0);
    int mem_start = w0 + 3;
    int n_ir = 0, n_rw = 0, n_pc = 0, n_mw = 0, ir_cyc = -1, end_cyc = -1;
    bit done = 0;
    logic zero_done = 1'b0;
    int exp_pc;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      op = iop; funct3 = if3; funct7b5 = if7;
      if (cyc < w0)                          MemReady = 1'b0;
      else if (cyc == w0)                    MemReady = 1'b1;
      else if (is_mem && cyc >= mem_start)   MemReady = (cyc >= mem_start + w1);
      else                                   MemReady = 1'($urandom_range(0, 1));
      Zero = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
      #1;
      n_ir += int'(IRWrite); n_rw += int'(RegWrite);
      n_pc += int'(PCWrite); n_mw += int'(MemWrite);
      if (IRWrite && ir_cyc < 0) ir_cyc = cyc;
      if ((cls == C_R || cls == C_I) && cyc == w0 + 2)
        check("exec_aluctl", {29'd0, ALUControl}, {29'd0, exp_alu(iop, if3, if7)});
      if (cls == C_BEQ && cyc == w0 + 2)
        check("beq_aluctl", {29'd0, ALUControl}, 32'd1);
      if (cls == C_ILL && cyc == w0 + 1) begin
        check("decode_illegal", {31'd0, Illegal}, 32'd0);
        done = 1;
        end_cyc = cyc;
      end else if (InstrDone) begin
        done = 1;
        end_cyc = cyc;
        zero_done = Zero;
        check("done_imm", {29'd0, ImmSrc}, {29'd0, exp_imm(iop)});
        check("done_result", {30'd0, ResultSrc},
              (cls == C_LW) ? 32'd1 : (cls == C_LUI) ? 32'd3 : 32'd0);
        check("done_illegal", {31'd0, Illegal}, 32'd0);
      end
    end
    if (!done) begin
      check("timeout", 32'd0, 32'd1);
    end else if (cls == C_ILL) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        MemReady = 1'($urandom_range(0, 1));
        Zero     = 1'($urandom_range(0, 1));
        #1;
        check("trap_illegal", {31'd0, Illegal}, 32'd1);
        check("trap_enables", {27'd0, PCWrite, IRWrite, RegWrite, MemWrite, InstrDone}, 32'd0);
      end
      apply_reset(1);
    end else begin
      exp_pc = 1 + ((cls == C_JAL || cls == C_JALR) ? 1 : 0) + ((cls == C_BEQ) ? int'(zero_done) : 0);
      check("cycles", end_cyc + 1, exp_cyc);
      check("irwrite_count", n_ir, 1);
      check("irwrite_cycle", ir_cyc, w0);
      check("regwrite_count", n_rw, (cls == C_SW || cls == C_BEQ) ? 0 : 1);
      check("pcwrite_count", n_pc, exp_pc);
      check("memwrite_count", n_mw, (cls == C_SW) ? w1 + 1 : 0);
    end
  endtask

  task automatic run_random;
    int cls = $urandom_range(0, 9);
    logic [2:0] ok_f3 [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
    logic [2:0] bad_f3 [4] = '{3'b001, 3'b011, 3'b100, 3'b101};
    logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    logic [2:0] f3 = 3'($urandom_range(0, 7));
    logic f7 = 1'($urandom_range(0, 1));
    int w0 = $urandom_range(0, 2);
    int w1 = $urandom_range(0, 3);
    if (cls == 8) begin
      run_instr(C_ILL, ($urandom_range(0, 1) != 0) ? 7'b1110011 : 7'b0010111, f3, f7, w0, w1, -1);
    end else if (cls == 9) begin
      run_instr(C_ILL, ($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011,
                bad_f3[$urandom_range(0, 3)], f7, w0, w1, -1);
    end else begin
      if (cls == C_R || cls == C_I) f3 = ok_f3[$urandom_range(0, 3)];
      run_instr(cls, ops[cls], f3, f7, w0, w1, -1);
    end
  endtask

  initial begin
    reset_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;
    apply_reset(2);

    // Reset in the middle of a stalled store
    @(negedge clk); op = 7'b0100011; MemReady = 1'b1;
    @(negedge clk); MemReady = 1'b0;
    @(negedge clk); MemReady = 1'b0;
    @(negedge clk); MemReady = 1'b0;
    #1;
    check("mid_store_memwrite", {31'd0, MemWrite}, 32'd1);
    apply_reset(2);

    // Directed cases
    run_instr(C_LW,   7'b0000011, 3'b010, 1'b0, 0, 2, -1);
    run_instr(C_R,    7'b0110011, 3'b000, 1'b1, 0, 0, -1);
    run_instr(C_I,    7'b0010011, 3'b000, 1'b1, 1, 0, -1);
    run_instr(C_BEQ,  7'b1100011, 3'b000, 1'b0, 0, 0, 1);
    run_instr(C_BEQ,  7'b1100011, 3'b000, 1'b0, 0, 0, 0);
    run_instr(C_JALR, 7'b1100111, 3'b000, 1'b0, 0, 0, -1);
    run_instr(C_JAL,  7'b1101111, 3'b000, 1'b0, 0, 0, -1);
    run_instr(C_LUI,  7'b0110111, 3'b000, 1'b0, 0, 0, -1);
    run_instr(C_SW,   7'b0100011, 3'b010, 1'b0, 1, 3, -1);
    run_instr(C_ILL,  7'b1110011, 3'b000, 1'b0, 0, 0, -1);
    run_instr(C_ILL,  7'b0110011, 3'b001, 1'b0, 0, 0, -1);

    for (int k = 0; k < 200; k++) run_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
